// File: rtl/effect_frame_sequencer_if.sv
// effect_frame_sequencer_if: frame-start handshake, frame RAM port and
// single-sample effect handshake seen by the frame sequencer.
// Ports (slave = sequencer side):
//   frame_start/gain_sel/bypass in, busy/frame_done/err out
//   rd_en/rd_addr out, rd_data in; wr_en/wr_addr/wr_data out
//   eff_start/eff_gain/eff_in out, eff_done/eff_out in
interface effect_frame_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic               frame_start;
    logic               gain_sel;
    logic               bypass;
    logic               busy;
    logic               frame_done;
    logic               err;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic signed [15:0] rd_data;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic signed [15:0] wr_data;
    logic               eff_start;
    logic               eff_gain;
    logic signed [15:0] eff_in;
    logic               eff_done;
    logic signed [15:0] eff_out;

    modport slave (
        input  frame_start, gain_sel, bypass,
        input  rd_data, eff_done, eff_out,
        output busy, frame_done, err,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output eff_start, eff_gain, eff_in
    );

    modport master (
        output frame_start, gain_sel, bypass,
        output rd_data, eff_done, eff_out,
        input  busy, frame_done, err,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  eff_start, eff_gain, eff_in
    );
endinterface

// File: rtl/effect_frame_sequencer.sv
// effect_frame_sequencer: streams one frame from RAM through a
// single-sample effect (START/DONE) and writes results back in place.
// Ports: clk, reset (sync, active-high), bus (effect_frame_sequencer_if.slave).
// Optional macro SEQ_TIMEOUT_EN: PROC watchdog of TIMEOUT cycles that
// writes the unprocessed sample and sets the sticky err flag.
module effect_frame_sequencer #(
    parameter int FRAME_LEN = 1000,
`ifdef SEQ_TIMEOUT_EN
    parameter int TIMEOUT   = 15,
`endif
    parameter int ADDR_W    = 10
) (
    input logic clk,
    input logic reset,
    effect_frame_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_LAT, S_PROC, S_WR, S_FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               gain_q, gain_d;
    logic               byp_q, byp_d;
    logic signed [15:0] sample_q, sample_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic signed [15:0] wr_data_q, wr_data_d;
    logic               eff_start_q, eff_start_d;

`ifdef SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
`endif

    // Outputs are registered: each *_d describes the cycle being entered.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gain_d      = gain_q;
        byp_d       = byp_q;
        sample_d    = sample_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        eff_start_d = 1'b0;
        done_d      = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    gain_d    = bus.gain_sel;
                    byp_d     = bus.bypass;
                    idx_d     = '0;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    state_d   = S_RD;
`ifdef SEQ_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                end
            end
            S_RD: begin
                state_d = S_LAT;
            end
            S_LAT: begin
                sample_d = bus.rd_data;
                if (byp_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = bus.rd_data;
                    state_d   = S_WR;
                end else begin
                    eff_start_d = 1'b1;
                    state_d     = S_PROC;
`ifdef SEQ_TIMEOUT_EN
                    tmo_d       = '0;
`endif
                end
            end
            S_PROC: begin
                // DONE checked first so it wins over a same-cycle timeout.
                if (bus.eff_done) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = bus.eff_out;
                    state_d   = S_WR;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = sample_q;
                    err_d     = 1'b1;
                    state_d   = S_WR;
                end
`endif
                else begin
                    eff_start_d = 1'b1;
`ifdef SEQ_TIMEOUT_EN
                    tmo_d       = tmo_q + 1'b1;
`endif
                end
            end
            S_WR: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    idx_d     = idx_q + 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = idx_q + 1'b1;
                    state_d   = S_RD;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            gain_q      <= 1'b0;
            byp_q       <= 1'b0;
            sample_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            eff_start_q <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gain_q      <= gain_d;
            byp_q       <= byp_d;
            sample_q    <= sample_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            eff_start_q <= eff_start_d;
`ifdef SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.eff_start  = eff_start_q;
    assign bus.eff_gain   = gain_q;
    assign bus.eff_in     = sample_q;
`ifdef SEQ_TIMEOUT_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_effect_frame_sequencer.sv
// tb_effect_frame_sequencer: frame RAM + overdrive effect models and a
// frame-level reference for effect_frame_sequencer.
module tb_effect_frame_sequencer;

    localparam int FL      = 4;
    localparam int AW      = 10;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    effect_frame_sequencer_if #(.ADDR_W(AW)) bus ();

    effect_frame_sequencer #(
        .FRAME_LEN(FL),
`ifdef SEQ_TIMEOUT_EN
        .TIMEOUT(TIMEOUT),
`endif
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [15:0] od(input logic signed [15:0] x,
                                              input logic g);
        int v;
        v = int'(x) * (g ? 3 : 2);
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    logic signed [15:0] img [0:FL-1];
    logic signed [15:0] ram [0:(1<<AW)-1];
    logic load_req = 1'b0;
    int   eff_p    = 2;
    int   hang_idx = -1;

    int   wr_cnt, addr_bad, hs_cnt, first_rd;
    logic gain_hi, gain_lo, start_seen;

    // Frame RAM (1-cycle read latency) plus bus monitors.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < FL; i++) ram[i] <= img[i];
            wr_cnt     <= 0;
            addr_bad   <= 0;
            hs_cnt     <= 0;
            first_rd   <= -1;
            gain_hi    <= 1'b0;
            gain_lo    <= 1'b0;
            start_seen <= 1'b0;
        end else begin
            if (bus.rd_en) begin
                bus.rd_data <= ram[bus.rd_addr];
                if (first_rd < 0) first_rd <= int'(bus.rd_addr);
            end
            if (bus.wr_en) begin
                ram[bus.wr_addr] <= bus.wr_data;
                if (int'(bus.wr_addr) != wr_cnt % FL) addr_bad <= addr_bad + 1;
                wr_cnt <= wr_cnt + 1;
            end
            if (bus.eff_start && bus.eff_done) hs_cnt <= hs_cnt + 1;
            if (bus.eff_start) start_seen <= 1'b1;
            if (bus.busy) begin
                if (bus.eff_gain) gain_hi <= 1'b1;
                else gain_lo <= 1'b1;
            end
        end
    end

    // Overdrive effect: DONE after eff_p-1 cycles of START, hangs on hang_idx.
    int   eff_cnt, samp_no;
    logic start_d;
    always @(posedge clk) begin
        if (load_req) begin
            eff_cnt      <= 0;
            samp_no      <= 0;
            start_d      <= 1'b0;
            bus.eff_done <= 1'b0;
            bus.eff_out  <= '0;
        end else begin
            start_d <= bus.eff_start;
            if (!bus.eff_start && start_d) samp_no <= samp_no + 1;
            if (bus.eff_start && !bus.eff_done) begin
                if (samp_no != hang_idx && eff_cnt >= eff_p - 2) begin
                    bus.eff_done <= 1'b1;
                    bus.eff_out  <= od(bus.eff_in, bus.eff_gain);
                    eff_cnt      <= 0;
                end else begin
                    eff_cnt <= eff_cnt + 1;
                end
            end else begin
                bus.eff_done <= 1'b0;
                eff_cnt      <= 0;
            end
        end
    end

    task automatic load_ram();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run_frame(input logic g, input logic b, input int p,
                             input int hang, input string nm);
        int   exp_lat, cyc, exp_hs;
        logic got_done;
        logic signed [15:0] expv [0:FL-1];
        eff_p    = p;
        hang_idx = hang;
        load_ram();
        exp_lat = 1;
        exp_hs  = 0;
        for (int i = 0; i < FL; i++) begin
            if (b) begin
                expv[i] = img[i];
                exp_lat += 3;
            end else if (i == hang) begin
                expv[i] = img[i];
                exp_lat += 3 + TIMEOUT;
            end else begin
                expv[i] = od(img[i], g);
                exp_lat += 3 + p;
                exp_hs++;
            end
        end
        bus.frame_start = 1'b1;
        bus.gain_sel    = g;
        bus.bypass      = b;
        @(negedge clk);
        cyc = 1;
        bus.frame_start = 1'b0;
        bus.gain_sel    = !g;
        bus.bypass      = !b;
        chk({nm, ".rd0"}, {bus.busy, bus.rd_en, bus.err}, 3'b110);
        chk({nm, ".rdaddr"}, 32'(bus.rd_addr), 0);
        got_done = 1'b0;
        while (cyc < 400) begin
            if (bus.frame_done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({nm, ".done"}, 32'(got_done), 1);
        chk({nm, ".lat"}, cyc, exp_lat);
        chk({nm, ".err"}, 32'(bus.err), 32'(hang >= 0));
        @(negedge clk);
        chk({nm, ".idle"}, {bus.busy, bus.frame_done}, 2'b00);
        chk({nm, ".wrcnt"}, wr_cnt, FL);
        chk({nm, ".addr"}, addr_bad, 0);
        chk({nm, ".first"}, first_rd, 0);
        chk({nm, ".hs"}, hs_cnt, exp_hs);
        chk({nm, ".start"}, 32'(start_seen), 32'(!b));
        chk({nm, ".gain"}, {gain_hi, gain_lo}, {g, !g});
        for (int i = 0; i < FL; i++)
            chk($sformatf("%s.ram%0d", nm, i), 32'(ram[i]), 32'(expv[i]));
    endtask

    initial begin
        int cyc, nd, n;
        int dt [0:2];
        logic signed [15:0] e3;

        reset = 1'b1;
        bus.frame_start = 1'b0;
        bus.gain_sel    = 1'b0;
        bus.bypass      = 1'b0;
        for (int i = 0; i < FL; i++) img[i] = '0;
        load_ram();
        repeat (2) @(negedge clk);
        chk("rst.flags", {bus.busy, bus.frame_done, bus.err, bus.rd_en,
                          bus.wr_en, bus.eff_start, bus.eff_gain}, 0);
        chk("rst.addr", {bus.rd_addr, bus.wr_addr}, 0);
        chk("rst.data", {bus.wr_data, bus.eff_in}, 0);
        reset = 1'b0;

        img[0] = 16'sd100;
        img[1] = -16'sd200;
        img[2] = 16'sd20000;
        img[3] = -16'sd20000;
        run_frame(1'b0, 1'b0, 2, -1, "x2");
        run_frame(1'b1, 1'b0, 2, -1, "x3");
        run_frame(1'b0, 1'b1, 2, -1, "byp");

        // Reset during the write of idx 1.
        eff_p    = 2;
        hang_idx = -1;
        load_ram();
        bus.frame_start = 1'b1;
        bus.gain_sel    = 1'b0;
        bus.bypass      = 1'b0;
        @(negedge clk);
        bus.frame_start = 1'b0;
        cyc = 0;
        while (!(bus.wr_en && bus.wr_addr == 1) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("mid.reach", 32'(bus.wr_en && bus.wr_addr == 1), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid.flags", {bus.busy, bus.frame_done, bus.err, bus.rd_en,
                          bus.wr_en, bus.eff_start, bus.eff_gain}, 0);
        chk("mid.data", {bus.wr_data, bus.eff_in}, 0);
        chk("mid.addr", {bus.rd_addr, bus.wr_addr}, 0);
        n = wr_cnt;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid.nowr", wr_cnt, n);
        chk("mid.busy", 32'(bus.busy), 0);
        run_frame(1'b0, 1'b0, 2, -1, "restart");

        // FRAME_START held high: three frames back to back.
        eff_p = 2;
        load_ram();
        bus.frame_start = 1'b1;
        bus.gain_sel    = 1'b0;
        bus.bypass      = 1'b0;
        cyc = 0;
        nd  = 0;
        while (nd < 3 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.frame_done) begin
                dt[nd] = cyc;
                nd++;
            end
        end
        bus.frame_start = 1'b0;
        chk("cont.n", nd, 3);
        chk("cont.t0", dt[0], 21);
        chk("cont.gap1", dt[1] - dt[0], 22);
        chk("cont.gap2", dt[2] - dt[1], 22);
        repeat (4) @(negedge clk);
        chk("cont.wr", wr_cnt, 3 * FL);
        chk("cont.addr", addr_bad, 0);
        chk("cont.busy", 32'(bus.busy), 0);
        for (int i = 0; i < FL; i++) begin
            e3 = od(od(od(img[i], 1'b0), 1'b0), 1'b0);
            chk($sformatf("cont.ram%0d", i), 32'(ram[i]), 32'(e3));
        end

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < FL; i++) img[i] = 16'($urandom);
            run_frame(1'($urandom), 1'($urandom), int'($urandom_range(2, 5)),
                      -1, $sformatf("rnd%0d", k));
        end

`ifdef SEQ_TIMEOUT_EN
        img[0] = 16'sd100;
        img[1] = -16'sd200;
        img[2] = 16'sd20000;
        img[3] = -16'sd20000;
        run_frame(1'b0, 1'b0, 2, 2, "tmo");
        run_frame(1'b0, 1'b0, 3, -1, "tmo_clr");
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/effect_frame_sequencer.md
# effect_frame_sequencer

Frame-level controller that streams one stored audio frame through a single-sample effect datapath (the overdrive stage: START/DONE handshake, 16-bit signed in/out, 1-bit gain select) and writes results back to the frame RAM in place. Sits between the frame buffer and the effect unit. It latches per-frame gain and bypass settings, sequences read → process → write per sample, and signals frame completion to the pedal-chain controller.

## Interface
- FRAME_LEN, 1000: samples per frame
- ADDR_W, 10: RAM address width; must satisfy 2^ADDR_W ≥ FRAME_LEN
- TIMEOUT, 15: max cycles in PROC before watchdog fires (only with SEQ_TIMEOUT_EN)

- CLK  in  1  clock; all logic on posedge
- RESET  in  1  synchronous, active-high reset
- FRAME_START  in  1  request to process one frame; sampled only in IDLE
- GAIN_SEL  in  1  gain select (0 = ×2, 1 = ×3); latched on accept
- BYPASS  in  1  1 = skip effect and copy samples; latched on accept
- BUSY  out  1  high in every state except IDLE
- FRAME_DONE  out  1  one-cycle pulse at frame end
- ERR  out  1  sticky watchdog flag
- RD_EN  out  1  RAM read strobe
- RD_ADDR  out  ADDR_W  RAM read address
- RD_DATA  in  16  signed RAM data, valid the cycle after RD_EN
- WR_EN  out  1  RAM write strobe
- WR_ADDR  out  ADDR_W  RAM write address
- WR_DATA  out  16  signed write data
- EFF_START  out  1  effect start, held high until EFF_DONE
- EFF_GAIN  out  1  gain to the effect, constant for the whole frame
- EFF_IN  out  16  signed sample to the effect, stable while EFF_START is high
- EFF_DONE  in  1  effect completion
- EFF_OUT  in  16  signed effect result, valid when EFF_DONE is 1

## Operation
- States: IDLE, RD, LAT, PROC, WR, FIN.
- IDLE:
  - If FRAME_START=1: latch GAIN_SEL and BYPASS, clear idx, clear ERR, go to RD.
  - Otherwise stay in IDLE.
- RD: RD_EN=1, RD_ADDR=idx. Go to LAT.
- LAT: capture RD_DATA into the sample register. Go to PROC, or to WR if bypass is latched.
- PROC:
  - EFF_START=1, EFF_IN=sample register.
  - When EFF_DONE=1: capture EFF_OUT into the result register, go to WR.
- WR:
  - WR_EN=1, WR_ADDR=idx, WR_DATA=result (or the sample register in bypass).
  - If idx = FRAME_LEN-1, go to FIN; else idx+1 and go to RD.
- FIN: FRAME_DONE=1 for one cycle, go to IDLE.
- Ignored inputs:
  - FRAME_START outside IDLE, including in FIN.
  - EFF_DONE outside PROC.
  - GAIN_SEL and BYPASS changes mid-frame.
- The sequencer passes data through unmodified. Saturation belongs to the effect. Exactly FRAME_LEN writes per frame, addresses 0..FRAME_LEN-1 ascending, each written once.
- Reset value of every output: 0. Reset also sets state to IDLE and clears idx, ERR and the latched settings. Reset mid-frame aborts immediately with no further RAM write. Partially written RAM is left as is.

## Timing
- Accept: FRAME_START high in IDLE at edge t puts RD active in cycle t+1.
- Per sample with a 1-cycle-DONE effect: RD 1 + LAT 1 + PROC 2 + WR 1 = 5 cycles.
- Per sample in bypass: 3 cycles.
- Frame latency (accept edge to FRAME_DONE pulse): 5·FRAME_LEN+1 cycles, or 3·FRAME_LEN+1 in bypass. BUSY falls in the cycle after FIN.
- EFF_START drops the cycle after EFF_DONE is sampled high, so one request produces exactly one handshake. A back-to-back FRAME_START is accepted in IDLE, one cycle after FIN.
- A slower effect extends PROC without bound (see Configuration).

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A counter runs in PROC. On the TIMEOUT-th PROC cycle without EFF_DONE: drop EFF_START, write the unprocessed sample, set ERR, continue with the next sample.
  - ERR holds until the next accepted FRAME_START or RESET.
  - EFF_DONE arriving on the same cycle as the timeout wins; ERR is not set.
- Undefined: PROC waits indefinitely; ERR is tied to 0.

## Test plan
- FRAME_LEN=4, RAM {100, -200, 20000, -20000}, GAIN_SEL=0, overdrive model attached:
  - RAM becomes {200, -400, 32767, -32768}.
  - FRAME_DONE pulses exactly 21 cycles after accept; 4 WR_EN pulses at addresses 0..3.
- Same RAM with GAIN_SEL=1 raised mid-frame after accepting with 0: EFF_GAIN stays 0 all frame and results match ×2.
- BYPASS=1: RAM unchanged, EFF_START never asserted, FRAME_DONE at 13 cycles.
- RESET asserted during the WR of idx 1: no further WR_EN, all outputs 0 next cycle. A following FRAME_START restarts at address 0.
- FRAME_START held high continuously: frames repeat with one IDLE cycle between FRAME_DONE and the next RD; no request is lost or doubled.
- SEQ_TIMEOUT_EN, effect model never asserts DONE on idx 2, TIMEOUT=15: after 15 PROC cycles RAM[2] keeps its input value, ERR=1 through FRAME_DONE, cleared on the next accept.
